regfile_2r1w: RTL and testbench

//  Parametrised register bank: 2 registered read ports, 1 write port, busy scoreboard.

---
 rtl/regbank_pkg.sv | 33 +++
 rtl/regfile_read_port.sv | 76 +++++++
 rtl/regfile_2r1w.sv | 181 ++++++++++++++++++
 tb/tb_regfile_2r1w.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// ---------------------------------------------------------------------------
// regbank_pkg
//   Shared constants for the register bank: default data width and register
//   count, the architectural indices of the reserved registers, and the
//   default write-protect mask built from them.
//
//   Also carries the single write-permission rule so the top level and any
//   future user of the bank agree on what "allowed" means.
// ---------------------------------------------------------------------------
package regbank_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 16;

  // Reserved registers: program counter, interrupt stack pointer and the
  // interrupt vector base. Only privileged writes may update them.
  localparam int REG_PC      = 13;
  localparam int REG_ISP     = 14;
  localparam int REG_INTBASE = 15;

  // Evaluates to 16'hE000 for the default register count.
  localparam logic [NUM_REGS_DEF-1:0] PROT_MASK_DEF =
      (NUM_REGS_DEF'(1) << REG_PC)  |
      (NUM_REGS_DEF'(1) << REG_ISP) |
      (NUM_REGS_DEF'(1) << REG_INTBASE);

  // A write to a register is permitted when the register is not protected,
  // or when the write carries privilege.
  function automatic logic wr_allowed(input logic prot, input logic priv);
    return (!prot) || priv;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
//   One registered read port of the register bank. Selects between the
//   stored register value, a same-cycle accepted write (write-first bypass)
//   and the hard-wired zero of r0, then captures the result together with
//   the post-update busy bit of the addressed register.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; clears data and busy outputs
//   rd_en_i      1: capture this cycle; 0: hold outputs
//   rd_addr_i    register index to read
//   reg_data_i   stored value of reg[rd_addr_i] (before this edge's write)
//   wr_accept_i  a write is being committed on this edge
//   wr_addr_i    address of that write
//   wr_data_i    data of that write
//   busy_next_i  scoreboard value that will be in effect after this edge
//   rd_data_o    registered read data
//   rd_busy_o    registered busy flag of the register that was read
// ---------------------------------------------------------------------------
module regfile_read_port #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit ZERO_R0  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  input  logic [DATA_W-1:0]   reg_data_i,
  input  logic                wr_accept_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [NUM_REGS-1:0] busy_next_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_busy_o
);

  logic [DATA_W-1:0] data_d, data_q;
  logic              busy_d, busy_q;
  logic              addr_is_zero;
  logic              bypass_hit;

  always_comb begin
    addr_is_zero = ZERO_R0 && (rd_addr_i == '0);
    // Only committed writes are forwarded; a rejected (protected or r0)
    // write never reaches wr_accept_i, so it can never leak onto the port.
    bypass_hit   = wr_accept_i && (wr_addr_i == rd_addr_i);

    data_d = reg_data_i;
    if (addr_is_zero) begin
      data_d = '0;
    end else if (bypass_hit) begin
      data_d = wr_data_i;
    end

    // Post-update busy: a claim issued this cycle is already visible, and a
    // write that completes this cycle already shows the register as free.
    busy_d = busy_next_i[rd_addr_i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else if (rd_en_i) begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign rd_data_o = data_q;
  assign rd_busy_o = busy_q;

endmodule

// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
//   Register bank between decode and writeback: two registered read ports
//   feeding the ALU operand registers, one write port, and a busy
//   scoreboard for long-latency producers. Reserved registers (PROT_MASK)
//   accept only privileged writes; any rejected attempt sets a sticky
//   protect-fault flag that only reset clears. With ZERO_R0 set, r0 reads as
//   zero, writes to it are dropped and claims of it are ignored.
//
// Ports
//   clk, reset            clock; synchronous active-high reset (wins over
//                         every other input in the same cycle)
//   rd_en                 capture both read ports this cycle, else hold
//   rd_a_addr, rd_b_addr  read addresses
//   rd_a_data, rd_b_data  registered read data, latency 1
//   rd_a_busy, rd_b_busy  registered post-update busy of the address read
//   wr_en, wr_addr,
//   wr_data, wr_priv      write port; wr_priv unlocks protected registers
//   claim_en, claim_addr  mark a register busy
//   busy_vec              current scoreboard, bit i = reg i busy
//   prot_fault            sticky flag, set by any rejected protected write
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// ---------------------------------------------------------------------------
module regfile_2r1w
  import regbank_pkg::*;
#(
  parameter int                  DATA_W    = DATA_W_DEF,
  parameter int                  NUM_REGS  = NUM_REGS_DEF,
  parameter int                  ADDR_W    = $clog2(NUM_REGS),
  parameter logic [NUM_REGS-1:0] PROT_MASK = PROT_MASK_DEF,
  parameter bit                  ZERO_R0   = 1'b0
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_a_addr,
  input  logic [ADDR_W-1:0]   rd_b_addr,
  output logic [DATA_W-1:0]   rd_a_data,
  output logic [DATA_W-1:0]   rd_b_data,
  output logic                rd_a_busy,
  output logic                rd_b_busy,

  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_priv,

  input  logic                claim_en,
  input  logic [ADDR_W-1:0]   claim_addr,

  output logic [NUM_REGS-1:0] busy_vec,
  output logic                prot_fault
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_d, busy_q;
  logic                fault_d, fault_q;

  // -------------------------------------------------------------------------
  // Write qualification
  //   A write to r0 under ZERO_R0 is neither accepted nor a fault: it simply
  //   disappears. Everything else is accepted or rejected on permission.
  // -------------------------------------------------------------------------
  logic wr_to_zero;
  logic wr_permitted;
  logic wr_accept;
  logic wr_reject;
  logic claim_ok;

  always_comb begin
    wr_to_zero   = ZERO_R0 && (wr_addr == '0);
    wr_permitted = wr_allowed(PROT_MASK[wr_addr], wr_priv);
    wr_accept    = wr_en && !wr_to_zero &&  wr_permitted;
    wr_reject    = wr_en && !wr_to_zero && !wr_permitted;
    claim_ok     = claim_en && !(ZERO_R0 && (claim_addr == '0));
  end

  // -------------------------------------------------------------------------
  // Scoreboard and fault next-state
  //   The clear from a completing write is applied before the set from a
  //   claim, so a claim and write to the same register leave it busy: the
  //   new producer's result is still outstanding.
  // -------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (wr_accept) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (claim_ok) begin
      busy_d[claim_addr] = 1'b1;
    end
    fault_d = fault_q | wr_reject;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_accept) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports
  //   Each port sees the pre-edge stored value plus the write that commits
  //   on the same edge, and picks write-first.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] reg_a_val;
  logic [DATA_W-1:0] reg_b_val;

  always_comb begin
    reg_a_val = regs_q[rd_a_addr];
    reg_b_val = regs_q[rd_b_addr];
  end

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_R0  (ZERO_R0)
  ) u_port_a (
    .clk         (clk),
    .reset       (reset),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_a_addr),
    .reg_data_i  (reg_a_val),
    .wr_accept_i (wr_accept),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .busy_next_i (busy_d),
    .rd_data_o   (rd_a_data),
    .rd_busy_o   (rd_a_busy)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_R0  (ZERO_R0)
  ) u_port_b (
    .clk         (clk),
    .reset       (reset),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_b_addr),
    .reg_data_i  (reg_b_val),
    .wr_accept_i (wr_accept),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .busy_next_i (busy_d),
    .rd_data_o   (rd_b_data),
    .rd_busy_o   (rd_b_busy)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy_vec   = busy_q;
  assign prot_fault = fault_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// ---------------------------------------------------------------------------
// tb_regfile_2r1w
//   Directed bench for regfile_2r1w (default parameters). Each driven cycle
//   pushes the hand-computed outputs expected after that edge; a monitor
//   pops and compares one entry per cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_regfile_2r1w;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  // {a_data, b_data, a_busy, b_busy, busy_vec, prot_fault}
  localparam int W = 2*DATA_W + 2 + NUM_REGS + 1;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset      = 1'b1;
  logic                rd_en      = 1'b0;
  logic [ADDR_W-1:0]   rd_a_addr  = '0;
  logic [ADDR_W-1:0]   rd_b_addr  = '0;
  logic [DATA_W-1:0]   rd_a_data;
  logic [DATA_W-1:0]   rd_b_data;
  logic                rd_a_busy;
  logic                rd_b_busy;
  logic                wr_en      = 1'b0;
  logic [ADDR_W-1:0]   wr_addr    = '0;
  logic [DATA_W-1:0]   wr_data    = '0;
  logic                wr_priv    = 1'b0;
  logic                claim_en   = 1'b0;
  logic [ADDR_W-1:0]   claim_addr = '0;
  logic [NUM_REGS-1:0] busy_vec;
  logic                prot_fault;

  regfile_2r1w dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .rd_a_addr  (rd_a_addr),
    .rd_b_addr  (rd_b_addr),
    .rd_a_data  (rd_a_data),
    .rd_b_data  (rd_b_data),
    .rd_a_busy  (rd_a_busy),
    .rd_b_busy  (rd_b_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_priv    (wr_priv),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy_vec   (busy_vec),
    .prot_fault (prot_fault)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           passes = 0;
  int           cyc_no = 0;
  logic         armed  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL cycle %0d %s: got %h expected %h", cyc_no, name, act, exp);
    end
  endtask

  // An entry pushed before a rising edge becomes comparable after that edge.
  always @(posedge clk) armed <= (exp_q.size() > 0);

  always @(negedge clk) begin
    if (armed && exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      cyc_no++;
      chk("rd_a_data",  32'(rd_a_data),  32'(e[W-1 -: DATA_W]));
      chk("rd_b_data",  32'(rd_b_data),  32'(e[W-1-DATA_W -: DATA_W]));
      chk("rd_a_busy",  32'(rd_a_busy),  32'(e[NUM_REGS+2]));
      chk("rd_b_busy",  32'(rd_b_busy),  32'(e[NUM_REGS+1]));
      chk("busy_vec",   32'(busy_vec),   32'(e[NUM_REGS:1]));
      chk("prot_fault", 32'(prot_fault), 32'(e[0]));
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic step(
    input logic rst, input logic re, input logic [3:0] ra, input logic [3:0] rb,
    input logic we, input logic [3:0] wa, input logic [15:0] wd, input logic pv,
    input logic ce, input logic [3:0] ca,
    input logic [15:0] ea, input logic [15:0] eb, input logic eab, input logic ebb,
    input logic [15:0] ebusy, input logic ef);
    @(negedge clk);
    reset      = rst;
    rd_en      = re;
    rd_a_addr  = ra;
    rd_b_addr  = rb;
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    wr_priv    = pv;
    claim_en   = ce;
    claim_addr = ca;
    exp_q.push_back({ea, eb, eab, ebb, ebusy, ef});
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    // 1. reset, then sweep every register on both ports
    step(1, 0, 0, 0,   0, 0, 16'h0,    0,  0, 0,   16'h0,    16'h0,    0, 0, 16'h0000, 0);
    step(1, 0, 0, 0,   0, 0, 16'h0,    0,  0, 0,   16'h0,    16'h0,    0, 0, 16'h0000, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 4'(i), 4'(i + 8), 0, 0, 16'h0, 0, 0, 0,
           16'h0, 16'h0, 0, 0, 16'h0000, 0);
    end
    // 2. write r3 (outputs hold), then read it on both ports
    step(0, 0, 0, 0,   1, 3, 16'hBEEF, 0,  0, 0,   16'h0,    16'h0,    0, 0, 16'h0000, 0);
    step(0, 1, 3, 3,   0, 0, 16'h0,    0,  0, 0,   16'hBEEF, 16'hBEEF, 0, 0, 16'h0000, 0);
    // 3. same-cycle bypass on A, stored value on B
    step(0, 1, 5, 3,   1, 5, 16'h1234, 0,  0, 0,   16'h1234, 16'hBEEF, 0, 0, 16'h0000, 0);
    step(0, 1, 5, 5,   0, 0, 16'h0,    0,  0, 0,   16'h1234, 16'h1234, 0, 0, 16'h0000, 0);
    // 4. protection: rejected write is not bypassed and sets the sticky fault
    step(0, 1, 13, 13, 1, 13, 16'h00FF, 0, 0, 0,   16'h0,    16'h0,    0, 0, 16'h0000, 1);
    step(0, 1, 13, 3,  0, 0, 16'h0,    0,  0, 0,   16'h0,    16'hBEEF, 0, 0, 16'h0000, 1);
    step(0, 1, 13, 13, 1, 13, 16'h00FF, 1, 0, 0,   16'h00FF, 16'h00FF, 0, 0, 16'h0000, 1);
    step(0, 1, 13, 5,  0, 0, 16'h0,    0,  0, 0,   16'h00FF, 16'h1234, 0, 0, 16'h0000, 1);
    step(1, 0, 0, 0,   0, 0, 16'h0,    0,  0, 0,   16'h0,    16'h0,    0, 0, 16'h0000, 0);
    step(0, 1, 13, 3,  0, 0, 16'h0,    0,  0, 0,   16'h0,    16'h0,    0, 0, 16'h0000, 0);
    // r12 is just below the protected range; r15 is the top of it
    step(0, 1, 12, 12, 1, 12, 16'h0C0C, 0, 0, 0,   16'h0C0C, 16'h0C0C, 0, 0, 16'h0000, 0);
    step(0, 1, 15, 12, 1, 15, 16'hAAAA, 0, 0, 0,   16'h0,    16'h0C0C, 0, 0, 16'h0000, 1);
    // 5. scoreboard: claim visible to a same-cycle read
    step(0, 1, 7, 12,  0, 0, 16'h0,    0,  1, 7,   16'h0,    16'h0C0C, 1, 0, 16'h0080, 1);
    step(0, 1, 7, 7,   0, 0, 16'h0,    0,  0, 0,   16'h0,    16'h0,    1, 1, 16'h0080, 1);
    // claim and write to the same register: claim wins
    step(0, 1, 7, 6,   1, 7, 16'h7777, 0,  1, 7,   16'h7777, 16'h0,    1, 0, 16'h0080, 1);
    step(0, 1, 7, 7,   1, 7, 16'h8888, 0,  0, 0,   16'h8888, 16'h8888, 0, 0, 16'h0000, 1);
    // rejected write does not clear busy; privileged write does
    step(0, 0, 0, 0,   0, 0, 16'h0,    0,  1, 14,  16'h8888, 16'h8888, 0, 0, 16'h4000, 1);
    step(0, 1, 14, 14, 1, 14, 16'h1414, 0, 0, 0,   16'h0,    16'h0,    1, 1, 16'h4000, 1);
    step(0, 1, 7, 14,  1, 14, 16'h1414, 1, 0, 0,   16'h8888, 16'h1414, 0, 0, 16'h0000, 1);
    // 6. hold while r2 changes and gets claimed
    step(0, 1, 2, 2,   1, 2, 16'h2222, 0,  0, 0,   16'h2222, 16'h2222, 0, 0, 16'h0000, 1);
    step(0, 0, 2, 2,   1, 2, 16'h3333, 0,  1, 2,   16'h2222, 16'h2222, 0, 0, 16'h0004, 1);
    step(0, 0, 2, 2,   0, 0, 16'h0,    0,  0, 0,   16'h2222, 16'h2222, 0, 0, 16'h0004, 1);
    step(0, 1, 2, 1,   0, 0, 16'h0,    0,  0, 0,   16'h3333, 16'h0,    1, 0, 16'h0004, 1);
    // reset beats a simultaneous read, privileged write and claim
    step(1, 1, 4, 2,   1, 4, 16'h4444, 1,  1, 4,   16'h0,    16'h0,    0, 0, 16'h0000, 0);
    step(0, 1, 4, 2,   0, 0, 16'h0,    0,  0, 0,   16'h0,    16'h0,    0, 0, 16'h0000, 0);

    // idle and let the monitor drain the queue, bounded
    @(negedge clk);
    reset    = 1'b0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    claim_en = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
